dmem_arbiter: RTL and testbench

Single-port data-RAM controller and arbiter. It shares one word-wide synchronous data RAM between the pipeline's MEM stage (core port) and an external host loader/debug port (host port). It performs byte/half/word lane alignment for stores, and extract plus sign/zero extension for loads. It drives the core's memory-ready input; the hazard unit stalls the pipeline while that input is low.

---
 rtl/dmem_arbiter_pkg.sv | 26 ++
 rtl/dmem_lane_align.sv | 53 +++++
 rtl/dmem_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// rtl/dmem_arbiter_pkg.sv - shared types, size codes and helpers for the data-memory arbiter
package dmem_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} dmem_state_t;
  typedef enum logic {CORE, HOST} grant_t;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Wide enough for a read latency of up to 4 cycles (counter holds latency-1)
  localparam int CNT_W = 2;

  // Codes outside the five legal sizes fall back to a full-word access
  function automatic size_t decode_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_BYTE;
      F3_H, F3_HU: return SZ_HALF;
      default:     return SZ_WORD;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// rtl/dmem_lane_align.sv - store lane placement / byte enables and load extract / extend
module dmem_lane_align
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int FUNC3_WIDTH = 3
) (
  input  logic [FUNC3_WIDTH-1:0] func3,
  input  logic [1:0]             offset,
  input  logic [DATA_WIDTH-1:0]  st_data,
  input  logic [DATA_WIDTH-1:0]  ld_word,
  output logic [3:0]             st_be,
  output logic [DATA_WIDTH-1:0]  st_word,
  output logic [DATA_WIDTH-1:0]  ld_data
);

  size_t      size;
  logic       is_unsigned;
  logic [7:0] byte_sel;
  logic [15:0] half_sel;

  assign size        = decode_size(func3);
  assign is_unsigned = func3[2];

  // Replicate the right-justified store data into every lane; enables pick the live lanes
  always_comb begin
    st_be   = 4'b1111;
    st_word = st_data;
    case (size)
      SZ_BYTE: begin
        st_be   = 4'b0001 << offset;
        st_word = {4{st_data[7:0]}};
      end
      SZ_HALF: begin
        st_be   = offset[1] ? 4'b1100 : 4'b0011;
        st_word = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  // Pick the addressed byte/half (low offset bits below the size are ignored) and extend
  always_comb begin
    byte_sel = ld_word[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? ld_word[31:16] : ld_word[15:0];
    case (size)
      SZ_BYTE: ld_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: ld_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: ld_data = ld_word;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - core/host arbiter for one synchronous data RAM; DMEM_MISALIGN_CHK_EN adds misalign trapping
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 14,
  parameter int FUNC3_WIDTH = 3,
  parameter int MEM_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   core_memRead,
  input  logic                   core_memWrite,
  input  logic [FUNC3_WIDTH-1:0] core_func3,
  input  logic [ADDR_WIDTH-1:0]  core_addr,
  input  logic [DATA_WIDTH-1:0]  core_wdata,
  output logic [DATA_WIDTH-1:0]  core_rdata,
  output logic                   core_ready,
  input  logic                   host_req,
  input  logic                   host_we,
  input  logic [ADDR_WIDTH-3:0]  host_addr,
  input  logic [DATA_WIDTH-1:0]  host_wdata,
  output logic [DATA_WIDTH-1:0]  host_rdata,
  output logic                   host_ack,
  output logic                   ram_en,
  output logic [3:0]             ram_be,
  output logic [ADDR_WIDTH-3:0]  ram_addr,
  output logic [DATA_WIDTH-1:0]  ram_wdata,
  input  logic [DATA_WIDTH-1:0]  ram_rdata
`ifdef DMEM_MISALIGN_CHK_EN
  ,
  output logic                   core_misalign
`endif
);

  dmem_state_t             state_q, state_d;
  grant_t                  grant_q, grant_d;
  grant_t                  last_grant_q, last_grant_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [FUNC3_WIDTH-1:0]  func3_q, func3_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    we_q, we_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   core_rdata_q, core_rdata_d;
  logic [DATA_WIDTH-1:0]   host_rdata_q, host_rdata_d;

  logic                    core_req;
  logic                    pick_core;
  logic [3:0]              st_be;
  logic [DATA_WIDTH-1:0]   st_word;
  logic [DATA_WIDTH-1:0]   ld_data;

  assign core_req   = core_memRead | core_memWrite;
  assign core_rdata = core_rdata_q;
  assign host_rdata = host_rdata_q;

  dmem_lane_align #(
    .DATA_WIDTH (DATA_WIDTH),
    .FUNC3_WIDTH(FUNC3_WIDTH)
  ) u_lane_align (
    .func3  (func3_q),
    .offset (addr_q[1:0]),
    .st_data(wdata_q),
    .ld_word(ram_rdata),
    .st_be  (st_be),
    .st_word(st_word),
    .ld_data(ld_data)
  );

`ifdef DMEM_MISALIGN_CHK_EN
  logic misalign_q, misalign_d;
  logic core_misaligned;

  // A half needs addr[0]==0 and a word needs addr[1:0]==0; bytes are always aligned
  always_comb begin
    case (decode_size(core_func3))
      SZ_HALF: core_misaligned = core_addr[0];
      SZ_WORD: core_misaligned = |core_addr[1:0];
      default: core_misaligned = 1'b0;
    endcase
  end

  // Misalign flag travels with the transaction into its RESP cycle
  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign core_misalign = !rst && (state_q == RESP) && misalign_q;
`endif

  // State and latched-request registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= HOST;
      last_grant_q <= HOST;
      addr_q       <= '0;
      func3_q      <= '0;
      wdata_q      <= '0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      core_rdata_q <= '0;
      host_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      func3_q      <= func3_d;
      wdata_q      <= wdata_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      core_rdata_q <= core_rdata_d;
      host_rdata_q <= host_rdata_d;
    end
  end

  // Next-state: round-robin grant in IDLE, fixed ACCESS/WAIT/RESP sequence afterwards
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    addr_d       = addr_q;
    func3_d      = func3_q;
    wdata_d      = wdata_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    core_rdata_d = core_rdata_q;
    host_rdata_d = host_rdata_q;
    pick_core    = core_req && (!host_req || last_grant_q == HOST);
`ifdef DMEM_MISALIGN_CHK_EN
    misalign_d   = misalign_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_core) begin
          grant_d = CORE;
          addr_d  = core_addr;
          func3_d = core_func3;
          wdata_d = core_wdata;
          we_d    = core_memWrite;
          state_d = ACCESS;
`ifdef DMEM_MISALIGN_CHK_EN
          misalign_d = core_misaligned;
          if (core_misaligned) begin
            state_d      = RESP;
            core_rdata_d = '0;
          end
`endif
        end else if (host_req) begin
          // Host traffic is always a full word, so it rides the W path of the aligner
          grant_d = HOST;
          addr_d  = {host_addr, 2'b00};
          func3_d = FUNC3_WIDTH'(F3_W);
          wdata_d = host_wdata;
          we_d    = host_we;
          state_d = ACCESS;
`ifdef DMEM_MISALIGN_CHK_EN
          misalign_d = 1'b0;
`endif
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          cnt_d   = CNT_W'(MEM_LATENCY - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          if (grant_q == CORE) core_rdata_d = ld_data;
          else                 host_rdata_d = ram_rdata;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        last_grant_d = grant_q;
        state_d      = IDLE;
`ifdef DMEM_MISALIGN_CHK_EN
        misalign_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: RAM strobe in ACCESS, completion handshakes in RESP, all quiet under reset
  always_comb begin
    ram_en     = 1'b0;
    ram_be     = 4'b0000;
    ram_addr   = addr_q[ADDR_WIDTH-1:2];
    ram_wdata  = '0;
    core_ready = !core_req;
    host_ack   = 1'b0;
    if (!rst) begin
      case (state_q)
        ACCESS: begin
          ram_en = 1'b1;
          if (we_q) begin
            ram_be    = st_be;
            ram_wdata = st_word;
          end
        end
        RESP: begin
          if (grant_q == CORE) core_ready = 1'b1;
          else                 host_ack   = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - scoreboard bench for dmem_arbiter with a behavioural RAM
module tb_dmem_arbiter;

  localparam int DW = 32;
  localparam int AW = 14;
  localparam int FW = 3;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_memRead, core_memWrite;
  logic [FW-1:0] core_func3;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;
  logic          core_ready;
  logic          host_req, host_we;
  logic [AW-3:0] host_addr;
  logic [DW-1:0] host_wdata, host_rdata;
  logic          host_ack;
  logic          ram_en;
  logic [3:0]    ram_be;
  logic [AW-3:0] ram_addr;
  logic [DW-1:0] ram_wdata, ram_rdata;
`ifdef DMEM_MISALIGN_CHK_EN
  logic          core_misalign;
  int            mis_cnt = 0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FUNC3_WIDTH(FW), .MEM_LATENCY(ML)
  ) dut (
    .clk(clk), .rst(rst),
    .core_memRead(core_memRead), .core_memWrite(core_memWrite),
    .core_func3(core_func3), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_rdata(core_rdata), .core_ready(core_ready),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata), .host_ack(host_ack),
    .ram_en(ram_en), .ram_be(ram_be), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
`ifdef DMEM_MISALIGN_CHK_EN
    , .core_misalign(core_misalign)
`endif
  );

  // Behavioural RAM: byte-enabled writes, reads valid ML cycles after the strobe
  logic [31:0] mem [0:4095];
  logic [31:0] rd_pipe [0:ML-1];
  assign ram_rdata = rd_pipe[ML-1];

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    for (int i = 0; i < ML; i++) rd_pipe[i] = 32'h0BAD_0BAD;
  end

  always @(posedge clk) begin
    if (ram_en) begin
      for (int b = 0; b < 4; b++)
        if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    rd_pipe[0] <= ram_en ? mem[ram_addr] : 32'h0BAD_0BAD;
    for (int i = 1; i < ML; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  typedef struct packed {
    logic [11:0] addr;
    logic [3:0]  be;
    logic [31:0] wd;
  } ram_exp_t;

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  lat;
  } rsp_exp_t;

  ram_exp_t ram_q[$];
  rsp_exp_t core_q[$];
  rsp_exp_t host_q[$];
  ram_exp_t mon_r;

  // Every RAM strobe must match the next expected strobe, in order
  always @(negedge clk) begin
    if (ram_en === 1'b1) begin
      n_cmp++;
      if (ram_q.size() == 0) begin
        n_err++;
        $display("FAIL ram_unexpected: addr=%h be=%b, required no strobe", ram_addr, ram_be);
      end else begin
        mon_r = ram_q.pop_front();
        if (ram_addr !== mon_r.addr || ram_be !== mon_r.be ||
            (mon_r.be != 4'b0000 && ram_wdata !== mon_r.wd)) begin
          n_err++;
          $display("FAIL ram_strobe: addr=%h be=%b wdata=%h, required addr=%h be=%b wdata=%h",
                   ram_addr, ram_be, ram_wdata, mon_r.addr, mon_r.be, mon_r.wd);
        end
      end
    end
`ifdef DMEM_MISALIGN_CHK_EN
    if (core_misalign === 1'b1) mis_cnt++;
`endif
  end

  function automatic ram_exp_t mk_ram(input logic [11:0] a, input logic [3:0] be, input logic [31:0] wd);
    ram_exp_t r;
    r.addr = a; r.be = be; r.wd = wd;
    return r;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    core_memRead = 1'b0; core_memWrite = 1'b0; core_func3 = '0; core_addr = '0; core_wdata = '0;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Called at posedge+1 with the DUT idle; latency counted from the assertion cycle
  task automatic core_access(input logic we, input logic [2:0] f3, input logic [13:0] addr,
                             input logic [31:0] wd, input logic [31:0] exp_d, input int exp_lat,
                             input string name);
    rsp_exp_t e;
    logic got;
    int lat;
    logic [31:0] d;
    e.data = exp_d; e.lat = 8'(exp_lat);
    core_q.push_back(e);
    core_memRead = !we; core_memWrite = we; core_func3 = f3; core_addr = addr; core_wdata = wd;
    got = 1'b0; lat = 0; d = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (core_ready === 1'b1) begin got = 1'b1; lat = c; d = core_rdata; break; end
    end
    @(posedge clk);
    #1 core_memRead = 1'b0; core_memWrite = 1'b0;
    e = core_q.pop_front();
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s_timeout: core_ready stayed low, required high within 60 cycles", name);
    end else begin
      if (lat != int'(e.lat)) begin
        n_err++;
        $display("FAIL %s_latency: %0d cycles, required %0d", name, lat, e.lat);
      end
      if (!we) begin
        n_cmp++;
        if (d !== e.data) begin
          n_err++;
          $display("FAIL %s_rdata: %h, required %h", name, d, e.data);
        end
      end
    end
  endtask

  task automatic host_access(input logic we, input logic [11:0] addr, input logic [31:0] wd,
                             input logic [31:0] exp_d, input int exp_lat, input string name);
    rsp_exp_t e;
    logic got;
    int lat;
    logic [31:0] d;
    e.data = exp_d; e.lat = 8'(exp_lat);
    host_q.push_back(e);
    host_req = 1'b1; host_we = we; host_addr = addr; host_wdata = wd;
    got = 1'b0; lat = 0; d = '0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (host_ack === 1'b1) begin got = 1'b1; lat = c; d = host_rdata; break; end
    end
    @(posedge clk);
    #1 host_req = 1'b0;
    e = host_q.pop_front();
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s_timeout: host_ack never pulsed, required within 60 cycles", name);
    end else begin
      if (lat != int'(e.lat)) begin
        n_err++;
        $display("FAIL %s_latency: %0d cycles, required %0d", name, lat, e.lat);
      end
      if (!we) begin
        n_cmp++;
        if (d !== e.data) begin
          n_err++;
          $display("FAIL %s_rdata: %h, required %h", name, d, e.data);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (ram_en !== 1'b0 || core_ready !== 1'b1 || host_ack !== 1'b0 ||
        core_rdata !== 32'h0 || host_rdata !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: ram_en=%b core_ready=%b host_ack=%b core_rdata=%h host_rdata=%h, required 0 1 0 0 0",
               ram_en, core_ready, host_ack, core_rdata, host_rdata);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_word_store_loads();
    ram_q.push_back(mk_ram(12'd4, 4'b1111, 32'hDEADBEEF));
    core_access(1'b1, 3'b010, 14'h10, 32'hDEADBEEF, 32'h0, 2, "sw");
    ram_q.push_back(mk_ram(12'd4, 4'b0000, 32'h0));
    core_access(1'b0, 3'b000, 14'h13, 32'h0, 32'hFFFFFFDE, ML + 2, "lb");
    ram_q.push_back(mk_ram(12'd4, 4'b0000, 32'h0));
    core_access(1'b0, 3'b100, 14'h13, 32'h0, 32'h000000DE, ML + 2, "lbu");
    ram_q.push_back(mk_ram(12'd4, 4'b0000, 32'h0));
    core_access(1'b0, 3'b001, 14'h12, 32'h0, 32'hFFFFDEAD, ML + 2, "lh");
    ram_q.push_back(mk_ram(12'd4, 4'b0000, 32'h0));
    core_access(1'b0, 3'b101, 14'h10, 32'h0, 32'h0000BEEF, ML + 2, "lhu");
    ram_q.push_back(mk_ram(12'd4, 4'b0000, 32'h0));
    core_access(1'b0, 3'b010, 14'h10, 32'h0, 32'hDEADBEEF, ML + 2, "lw");
  endtask

  task automatic test_host();
    ram_q.push_back(mk_ram(12'd1, 4'b1111, 32'h11223344));
    host_access(1'b1, 12'd1, 32'h11223344, 32'h0, 2, "host_wr");
    ram_q.push_back(mk_ram(12'd4, 4'b0000, 32'h0));
    host_access(1'b0, 12'd4, 32'h0, 32'hDEADBEEF, ML + 2, "host_rd");
  endtask

  task automatic test_sub_word();
    ram_q.push_back(mk_ram(12'd1, 4'b0010, 32'hAAAAAAAA));
    core_access(1'b1, 3'b000, 14'h5, 32'h000000AA, 32'h0, 2, "sb");
    ram_q.push_back(mk_ram(12'd1, 4'b0000, 32'h0));
    core_access(1'b0, 3'b010, 14'h4, 32'h0, 32'h1122AA44, ML + 2, "lw_after_sb");
    ram_q.push_back(mk_ram(12'd3, 4'b1100, 32'h12341234));
    core_access(1'b1, 3'b001, 14'hE, 32'hFFFF1234, 32'h0, 2, "sh_hi");
    ram_q.push_back(mk_ram(12'd3, 4'b0000, 32'h0));
    core_access(1'b0, 3'b101, 14'hE, 32'h0, 32'h00001234, ML + 2, "lhu_hi");
    ram_q.push_back(mk_ram(12'd4, 4'b0000, 32'h0));
    core_access(1'b0, 3'b011, 14'h10, 32'h0, 32'hDEADBEEF, ML + 2, "f3_011_as_w");
  endtask

  task automatic test_misaligned();
`ifdef DMEM_MISALIGN_CHK_EN
    mis_cnt = 0;
    core_access(1'b0, 3'b010, 14'h6, 32'h0, 32'h0, 1, "lw_misalign");
    n_cmp++;
    if (mis_cnt != 1) begin
      n_err++;
      $display("FAIL misalign_pulse: %0d cycles high, required 1", mis_cnt);
    end
`else
    ram_q.push_back(mk_ram(12'd1, 4'b0000, 32'h0));
    core_access(1'b0, 3'b010, 14'h6, 32'h0, 32'h1122AA44, ML + 2, "lw_misalign");
`endif
  endtask

  task automatic test_contention();
    do_reset();
    ram_q.push_back(mk_ram(12'd4, 4'b0000, 32'h0));
    ram_q.push_back(mk_ram(12'd2, 4'b1111, 32'hCAFEF00D));
    fork
      core_access(1'b0, 3'b010, 14'h10, 32'h0, 32'hDEADBEEF, ML + 2, "cont_core");
      host_access(1'b1, 12'd2, 32'hCAFEF00D, 32'h0, ML + 5, "cont_host");
    join
  endtask

  task automatic test_back_to_back();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ram_q.push_back(mk_ram(12'd4, 4'b0000, 32'h0));
      ram_q.push_back(mk_ram(12'd2, 4'b0000, 32'h0));
    end
    fork
      for (int i = 0; i < 3; i++)
        core_access(1'b0, 3'b010, 14'h10, 32'h0, 32'hDEADBEEF, (i == 0) ? ML + 2 : 2 * ML + 5, "rr_core");
      for (int j = 0; j < 3; j++)
        host_access(1'b0, 12'd2, 32'h0, 32'hCAFEF00D, 2 * ML + 5, "rr_host");
    join
  endtask

  task automatic test_reset_mid();
    logic got;
    int lat;
    logic [31:0] d;
    ram_q.push_back(mk_ram(12'd4, 4'b0000, 32'h0));
    ram_q.push_back(mk_ram(12'd4, 4'b0000, 32'h0));
    core_memRead = 1'b1; core_func3 = 3'b010; core_addr = 14'h10;
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (core_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_ready: core_ready=%b during reset, required 0", core_ready);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (ram_en !== 1'b0 || core_ready !== 1'b0 || host_ack !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_idle: ram_en=%b core_ready=%b host_ack=%b, required 0 0 0",
               ram_en, core_ready, host_ack);
    end
    got = 1'b0; lat = 0; d = '0;
    for (int c = 4; c < 60; c++) begin
      @(negedge clk);
      if (core_ready === 1'b1) begin got = 1'b1; lat = c; d = core_rdata; break; end
    end
    @(posedge clk);
    #1 core_memRead = 1'b0;
    n_cmp++;
    if (!got || lat != ML + 5 || d !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL rst_mid_reissue: got=%b cycle=%0d rdata=%h, required 1 %0d DEADBEEF",
               got, lat, d, ML + 5);
    end
  endtask

  initial begin
    test_reset();
    test_word_store_loads();
    test_host();
    test_sub_word();
    test_misaligned();
    test_contention();
    test_back_to_back();
    test_reset_mid();
    repeat (4) @(posedge clk);
    n_cmp++;
    if (ram_q.size() != 0) begin
      n_err++;
      $display("FAIL ram_drain: %0d strobes outstanding, required 0", ram_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
